// File: rtl/reg_dump_streamer.sv
// Streams register-file contents, one beat per register, over a valid/ready port.
// Dumps start on start_i or once, automatically, TRIG_COUNT clocks after reset release.
module reg_dump_streamer #(
  parameter int DATA_W     = 32,
  parameter int LAST_REG   = 12,
  parameter int TRIG_COUNT = 25
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [4:0]        rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [4:0]        out_idx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0]  LAST_IDX = 5'(LAST_REG);
  localparam logic [15:0] TRIG_SAT = 16'(TRIG_COUNT);
  localparam logic        TRIG_EN  = (TRIG_COUNT != 0);

  logic [1:0]        state_reg, state_next;
  logic [4:0]        idx_reg, idx_next;
  logic [15:0]       cnt_reg;
  logic              req_reg;
  logic              auto_hit;
  logic [DATA_W-1:0] data_reg;
  logic [4:0]        out_idx_reg;

  // Fires only on the edge where the counter steps onto TRIG_COUNT; saturation keeps it one-shot.
  assign auto_hit = TRIG_EN && (cnt_reg == TRIG_SAT - 16'd1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_reg <= '0;
    end else if (cnt_reg != TRIG_SAT) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  // Start requests are registered; one is accepted only while idle with nothing pending.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_reg <= 1'b0;
    end else begin
      req_reg <= (state_reg == S_IDLE) && !req_reg && (start_i || auto_hit);
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_reg) begin
          state_next = S_READ;
          idx_next   = 5'd0;
        end
      end
      S_READ: state_next = S_SEND;
      S_SEND: begin
        if (out_ready_i) begin
          if (idx_reg == LAST_IDX) begin
            state_next = S_DONE;
          end else begin
            idx_next   = idx_reg + 5'd1;
            state_next = S_READ;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg   <= S_IDLE;
      idx_reg     <= 5'd0;
      data_reg    <= '0;
      out_idx_reg <= 5'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (state_reg == S_READ) begin
        data_reg    <= rf_data_i;
        out_idx_reg <= idx_reg;
      end
    end
  end

  assign rf_addr_o   = (state_reg == S_READ || state_reg == S_SEND) ? idx_reg : 5'd0;
  assign out_valid_o = (state_reg == S_SEND);
  assign out_data_o  = data_reg;
  assign out_idx_o   = out_idx_reg;
  assign busy_o      = (state_reg != S_IDLE);
  assign done_o      = (state_reg == S_DONE);

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Self-checking bench: auto-start timing, single-register vector table, and
// randomized/stalled/reset dumps checked against a per-register expected stream.
module tb_reg_dump_streamer;

  localparam int DW = 32;
  localparam int LR = 12;
  localparam int TC = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Instance with default parameters (auto-start)
  logic        a_start = 1'b0, a_ready = 1'b1;
  logic        a_valid, a_busy, a_done;
  logic [4:0]  a_addr, a_idx;
  logic [31:0] a_rf, a_data;
  assign a_rf = 32'(a_addr) * 32'd3;

  reg_dump_streamer #(.DATA_W(DW), .LAST_REG(LR), .TRIG_COUNT(TC)) u_auto (
    .clk_i(clk), .rst_i(rst_n), .start_i(a_start), .rf_addr_o(a_addr), .rf_data_i(a_rf),
    .out_valid_o(a_valid), .out_ready_i(a_ready), .out_data_o(a_data), .out_idx_o(a_idx),
    .busy_o(a_busy), .done_o(a_done));

  // Manual-start instance
  logic        m_start = 1'b0, m_ready = 1'b1;
  logic        m_valid, m_busy, m_done;
  logic [4:0]  m_addr, m_idx;
  logic [31:0] m_rf, m_data;
  logic [31:0] m_mem [32];
  assign m_rf = m_mem[m_addr];

  reg_dump_streamer #(.DATA_W(DW), .LAST_REG(LR), .TRIG_COUNT(0)) u_man (
    .clk_i(clk), .rst_i(rst_n), .start_i(m_start), .rf_addr_o(m_addr), .rf_data_i(m_rf),
    .out_valid_o(m_valid), .out_ready_i(m_ready), .out_data_o(m_data), .out_idx_o(m_idx),
    .busy_o(m_busy), .done_o(m_done));

  // Single-register instance
  logic        o_start = 1'b0, o_ready = 1'b1;
  logic        o_valid, o_busy, o_done;
  logic [4:0]  o_addr, o_idx;
  logic [31:0] o_rf0 = 32'h0, o_data;

  reg_dump_streamer #(.DATA_W(DW), .LAST_REG(0), .TRIG_COUNT(0)) u_one (
    .clk_i(clk), .rst_i(rst_n), .start_i(o_start), .rf_addr_o(o_addr), .rf_data_i(o_rf0),
    .out_valid_o(o_valid), .out_ready_i(o_ready), .out_data_o(o_data), .out_idx_o(o_idx),
    .busy_o(o_busy), .done_o(o_done));

  typedef struct {
    logic        start;
    logic        ready;
    logic [31:0] rf0;
    logic        v;
    logic        b;
    logic        d;
    logic [31:0] data;
  } vec_t;
  vec_t tbl [16];

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;
  beat_t m_q [$];
  int    m_done_cnt = 0;

  // Monitor: collects accepted beats, counts done pulses, checks hold-while-stalled.
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [4:0]  prev_idx = 5'd0;
  logic [31:0] prev_data = 32'd0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (m_valid && m_ready) m_q.push_back('{m_idx, m_data});
        if (m_done) m_done_cnt++;
        if (prev_v && !prev_r) begin
          n_assert++;
          if (!(m_valid && m_idx == prev_idx && m_data == prev_data)) begin
            n_fail++;
            $display("FAIL hold_stable: got v=%0b idx=%0d data=0x%0h, expected v=1 idx=%0d data=0x%0h",
                     m_valid, m_idx, m_data, prev_idx, prev_data);
          end
        end
        prev_v = m_valid; prev_r = m_ready; prev_idx = m_idx; prev_data = m_data;
      end
    end
  end

  // mode 0: random ready, 1: toggling ready, 2: 20-cycle stall on idx 5, 3: start pulse during idx 3
  task automatic man_dump(input int mode, input string tag);
    int cyc;
    int stall;
    m_q.delete();
    m_done_cnt = 0;
    stall = 0;
    @(posedge clk); #2;
    m_start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #2;
    m_start = 1'b0;
    cyc = 0;
    while (m_done_cnt == 0 && cyc < 400) begin
      case (mode)
        0: m_ready = 1'($urandom_range(0, 1));
        1: m_ready = ~m_ready;
        2: begin
          if (m_valid && m_idx == 5'd5 && stall < 20) begin
            chk({tag, "_stall_valid"}, m_valid, 1);
            chk({tag, "_stall_data"}, m_data, m_mem[5]);
            m_ready = 1'b0;
            stall++;
          end else begin
            m_ready = 1'b1;
          end
        end
        default: begin
          m_ready = 1'b1;
          m_start = (m_valid && m_idx == 5'd3);
        end
      endcase
      @(posedge clk); #2;
      cyc++;
    end
    m_start = 1'b0;
    m_ready = 1'b1;
    chk({tag, "_timeout"}, (cyc < 400) ? 32'd1 : 32'd0, 1);
    if (mode == 2) chk({tag, "_stall_cycles"}, stall, 20);
    repeat (10) @(posedge clk);
    #2;
    chk({tag, "_busy_after"}, m_busy, 0);
    chk({tag, "_addr_idle"}, m_addr, 0);
    chk({tag, "_done_pulses"}, m_done_cnt, 1);
    chk({tag, "_beat_count"}, m_q.size(), LR + 1);
    for (int i = 0; i < m_q.size() && i <= LR; i++) begin
      chk($sformatf("%s_idx%0d", tag, i), m_q[i].idx, i);
      chk($sformatf("%s_data%0d", tag, i), m_q[i].data, m_mem[i]);
    end
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    int first;
    int last;
    logic ev;
    int cyc;

    for (int i = 0; i < 32; i++) m_mem[i] = 32'(i * 3);

    tbl[0]  = '{1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'hA5A50001, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 32'hA5A50001, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'hA5A50001, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'hA5A50001, 1'b1, 1'b1, 1'b0, 32'hA5A50001};
    tbl[10] = '{1'b0, 1'b0, 32'hA5A50001, 1'b1, 1'b1, 1'b0, 32'hA5A50001};
    tbl[11] = '{1'b0, 1'b1, 32'hA5A50001, 1'b1, 1'b1, 1'b0, 32'hA5A50001};
    tbl[12] = '{1'b1, 1'b1, 32'hA5A50001, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[13] = '{1'b0, 1'b1, 32'hA5A50001, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 1'b1, 32'hA5A50001, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 1'b1, 32'hA5A50001, 1'b0, 1'b0, 1'b0, 32'h0};

    // Reset state
    #12;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_idx", m_idx, 0);
    chk("rst_o_busy", o_busy, 0);

    // Auto-start: trigger on edge TC, first beat on edge TC+2, two edges per beat
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    first = TC + 2;
    last  = first + 2 * LR;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      ev = (k >= first && k <= last && ((k - first) % 2 == 0));
      chk($sformatf("auto_valid_e%0d", k), a_valid, ev);
      chk($sformatf("auto_busy_e%0d", k), a_busy, (k >= first - 1 && k <= last + 1));
      chk($sformatf("auto_done_e%0d", k), a_done, (k == last + 1));
      chk($sformatf("auto_addr_e%0d", k), a_addr,
          (k >= first - 1 && k <= last) ? 32'((k - first + 1) / 2) : 32'd0);
      if (ev) begin
        chk($sformatf("auto_idx_e%0d", k), a_idx, (k - first) / 2);
        chk($sformatf("auto_data_e%0d", k), a_data, 3 * ((k - first) / 2));
      end
    end

    // Single-register instance, cycle-by-cycle table
    for (int r = 0; r < 16; r++) begin
      @(posedge clk); #2;
      o_start = tbl[r].start;
      o_ready = tbl[r].ready;
      o_rf0   = tbl[r].rf0;
      #1;
      chk($sformatf("one_valid_r%0d", r), o_valid, tbl[r].v);
      chk($sformatf("one_busy_r%0d", r), o_busy, tbl[r].b);
      chk($sformatf("one_done_r%0d", r), o_done, tbl[r].d);
      chk($sformatf("one_addr_r%0d", r), o_addr, 0);
      if (tbl[r].v) begin
        chk($sformatf("one_data_r%0d", r), o_data, tbl[r].data);
        chk($sformatf("one_idx_r%0d", r), o_idx, 0);
      end
    end
    o_start = 1'b0;
    o_ready = 1'b1;

    // Manual dumps: random data/ready, toggling ready, stall, start during SEND
    for (int i = 0; i < 32; i++) m_mem[i] = $urandom;
    man_dump(0, "rand0");
    for (int i = 0; i < 32; i++) m_mem[i] = $urandom;
    man_dump(0, "rand1");
    for (int i = 0; i < 32; i++) m_mem[i] = 32'(i * 3);
    man_dump(1, "toggle");
    man_dump(2, "stall");
    man_dump(3, "start_in_send");

    // Asynchronous reset during beat 7
    m_q.delete();
    m_done_cnt = 0;
    @(posedge clk); #2;
    m_start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #2;
    m_start = 1'b0;
    cyc = 0;
    while (!(m_valid && m_idx == 5'd7) && cyc < 100) begin
      @(posedge clk); #2;
      cyc++;
    end
    chk("arst_reach_idx7", (cyc < 100) ? 32'd1 : 32'd0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_busy", m_busy, 0);
    chk("arst_addr", m_addr, 0);
    chk("arst_idx", m_idx, 0);
    chk("arst_data", m_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    chk("arst_no_done", m_done_cnt, 0);
    chk("arst_stays_idle", m_busy, 0);
    man_dump(1, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
